// File: rtl/life_manager.sv
// Player-health controller: hazard damage, post-hit invulnerability with blink,
// heal pickups, fall-out death and a timed DYING -> OVER sequence.
module life_manager #(
    parameter int unsigned LIFE_W      = 4,
    parameter int unsigned MAX_LIFE    = 5,
    parameter int unsigned N_HAZARD    = 3,
    parameter int unsigned CD_W        = 27,
    parameter int unsigned COOLDOWN    = 100000000,
    parameter int unsigned DEATH_DELAY = 50000000,
    parameter int unsigned BLINK_BIT   = 22,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned V_H         = 480
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         restart_sw,
    input  logic [3:0]                   stage,
    input  logic [Y_W-1:0]               chara_y,
    input  logic                         chara_hit,
    input  logic [N_HAZARD-1:0]          hazard_hit,
    input  logic [N_HAZARD*LIFE_W-1:0]   hazard_dmg,
    input  logic                         heal_pulse,
    output logic [LIFE_W-1:0]            life,
    output logic [1:0]                   state,
    output logic                         gameover,
    output logic                         invuln,
    output logic                         visible,
    output logic                         hit_pulse
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DYING  = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [LIFE_W-1:0] LIFE_FULL = LIFE_W'(MAX_LIFE);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN - 1);
    localparam logic [CD_W-1:0]   DD_LOAD   = CD_W'(DEATH_DELAY - 1);
    localparam logic [Y_W-1:0]    FALL_Y    = Y_W'(V_H);

    state_t              cur;
    state_t              cur_n;
    logic [LIFE_W-1:0]   life_q;
    logic [LIFE_W-1:0]   life_n;
    logic [CD_W-1:0]     counter;
    logic [CD_W-1:0]     counter_n;
    logic                pulse_n;
    logic [3:0]          prev_stage;
    logic                prev_sw;

    logic                restart;
    logic [LIFE_W-1:0]   dmg;
    logic                hit_valid;
    logic                fall;
    logic [LIFE_W-1:0]   life_dec;
    logic [LIFE_W-1:0]   life_inc;

    assign restart = ~reset_n | (stage != prev_stage) | (restart_sw & ~prev_sw);

    // Overlapping hazards take the worst single damage, never the sum.
    always_comb begin
        dmg = '0;
        for (int unsigned i = 0; i < N_HAZARD; i++) begin
            if (hazard_hit[i] && (hazard_dmg[i*LIFE_W +: LIFE_W] > dmg))
                dmg = hazard_dmg[i*LIFE_W +: LIFE_W];
        end
    end

    assign hit_valid = chara_hit && (dmg != '0);
    assign fall      = (chara_y >= FALL_Y);
    assign life_dec  = (life_q > dmg) ? (life_q - dmg) : '0;
    assign life_inc  = (life_q >= LIFE_FULL) ? LIFE_FULL : (life_q + 1'b1);

    always_comb begin
        cur_n     = cur;
        life_n    = life_q;
        counter_n = counter;
        pulse_n   = 1'b0;
        case (cur)
            ALIVE: begin
                if (fall) begin
                    life_n    = '0;
                    cur_n     = DYING;
                    counter_n = DD_LOAD;
                end else if (hit_valid) begin
                    life_n  = life_dec;
                    pulse_n = 1'b1;
                    if (life_dec == '0) begin
                        cur_n     = DYING;
                        counter_n = DD_LOAD;
                    end else begin
                        cur_n     = INVULN;
                        counter_n = CD_LOAD;
                    end
                end else if (heal_pulse) begin
                    life_n = life_inc;
                end
            end
            INVULN: begin
                if (fall) begin
                    life_n    = '0;
                    cur_n     = DYING;
                    counter_n = DD_LOAD;
                end else begin
                    if (heal_pulse)
                        life_n = life_inc;
                    if (counter == '0) begin
                        cur_n     = ALIVE;
                        counter_n = '0;
                    end else begin
                        counter_n = counter - 1'b1;
                    end
                end
            end
            DYING: begin
                life_n = '0;
                if (counter == '0) begin
                    cur_n     = OVER;
                    counter_n = '0;
                end else begin
                    counter_n = counter - 1'b1;
                end
            end
            default: begin
                life_n = '0;
            end
        endcase
        if (restart) begin
            cur_n     = ALIVE;
            life_n    = LIFE_FULL;
            counter_n = '0;
            pulse_n   = 1'b0;
        end
    end

    // Flags are derived from next-state values so they line up with state/life.
    always_ff @(posedge clk) begin
        prev_stage <= stage;
        prev_sw    <= restart_sw;
        cur        <= cur_n;
        life_q     <= life_n;
        counter    <= counter_n;
        hit_pulse  <= pulse_n;
        invuln     <= (cur_n == INVULN);
        gameover   <= (cur_n == OVER);
        visible    <= (cur_n != INVULN) | counter_n[BLINK_BIT];
    end

    assign life  = life_q;
    assign state = cur;

endmodule

// File: doc/life_manager.md
Name: life_manager

Overview:
Parametrised player-health controller for the game pipeline. It sits between the collision/region logic and the HUD/renderer.
- Tracks life points against N hazard channels, each with its own damage weight.
- Applies a post-hit invulnerability window with a sprite blink flag, and accepts heal pickups.
- Sequences death through a fixed delay into a sticky game-over state.
- Restarts on reset, on a stage change or on a restart-switch rising edge.

Parameters:
LIFE_W, 4, width of life counter and per-hazard damage fields
MAX_LIFE, 5, life after restart and heal ceiling (must be < 2^LIFE_W)
N_HAZARD, 3, number of hazard channels
CD_W, 27, invulnerability/death counter width
COOLDOWN, 100000000, invulnerability length in cycles (1 .. 2^CD_W-1)
DEATH_DELAY, 50000000, cycles spent in DYING before OVER (1 .. 2^CD_W-1)
BLINK_BIT, 22, counter bit used for the blink phase (< CD_W)
Y_W, 10, character y width
V_H, 480, fall-out threshold on chara_y

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
restart_sw  in  1  restart switch level; rising edge restarts
stage  in  4  current stage; any change restarts
chara_y  in  Y_W  character top y
chara_hit  in  1  character overlaps an active region
hazard_hit  in  N_HAZARD  per-hazard overlap flags
hazard_dmg  in  N_HAZARD*LIFE_W  packed damage, hazard i at [i*LIFE_W +: LIFE_W]
heal_pulse  in  1  one-cycle heal pickup
life  out  LIFE_W  current life
state  out  2  0=ALIVE 1=INVULN 2=DYING 3=OVER
gameover  out  1  high only in OVER
invuln  out  1  high only in INVULN
visible  out  1  sprite draw enable (blink)
hit_pulse  out  1  one-cycle pulse on each applied hit

Behaviour:
- prev_stage and prev_sw are registered every cycle. While reset_n is low they load the current stage and restart_sw, so no spurious restart follows reset.
- restart = ~reset_n | (stage != prev_stage) | (restart_sw & ~prev_sw). It is synchronous and overrides everything.
- On restart: life=MAX_LIFE, state=ALIVE, counter=0, gameover=0, invuln=0, visible=1, hit_pulse=0.
- Hit damage:
  - dmg = max of hazard_dmg[i] over i with hazard_hit[i]=1. Simultaneous hazards are not summed.
  - A hit is valid when chara_hit=1 and dmg!=0. All-zero hit flags or dmg=0 is ignored.
- ALIVE:
  - Fall (chara_y >= V_H) has top priority: life<=0, state<=DYING, counter<=DEATH_DELAY-1.
  - Else on a valid hit: life<=sat0(life-dmg), hit_pulse<=1 next cycle. If the result is 0 -> DYING with counter=DEATH_DELAY-1. Otherwise -> INVULN with counter=COOLDOWN-1.
  - Else on heal_pulse: life<=min(life+1, MAX_LIFE).
  - In a cycle with both hit and heal, the hit wins and the heal is dropped.
- INVULN:
  - Hits are ignored.
  - Fall is still fatal, with the same handling as in ALIVE.
  - Heal is applied as in ALIVE.
  - counter decrements each cycle. In the cycle counter==0, state<=ALIVE. Window length is exactly COOLDOWN cycles.
  - A hit is accepted on the first ALIVE cycle.
- DYING: all inputs except restart are ignored and life holds 0. counter decrements. When counter==0, state<=OVER. Dwell is DEATH_DELAY cycles.
- OVER: sticky until restart. gameover=1, life=0.
- Registered outputs:
  - invuln = (state==INVULN).
  - visible = ~invuln | counter[BLINK_BIT]. visible is forced to 1 in ALIVE and OVER, and to 1 in DYING.
  - hit_pulse is high for exactly one cycle per applied hit, and never for ignored or fall events.
- Life arithmetic is unsigned, saturating at 0 and at MAX_LIFE. No wrap is permitted.
- Restart during any state, including mid-INVULN or mid-DYING, returns to full reset values on the next edge.

Test Plan:
- Use parameters COOLDOWN=8, DEATH_DELAY=4, MAX_LIFE=5, BLINK_BIT=1 throughout.
- Single hit: hazard_dmg={1,2,1}, assert chara_hit with hazard_hit=3'b010 for 1 cycle -> life 5->3, hit_pulse one cycle, invuln high 8 cycles, visible toggles every 2 cycles, then ALIVE.
- Hold chara_hit with hazard_hit=3'b111 for 20 cycles -> damage 2 per hit (max, not sum), hits applied 9 cycles apart, life 5->3->1->0. After the last hit DYING lasts 4 cycles, then gameover=1 and stays high.
- Heal and saturation:
  - heal_pulse at life=5 -> life stays 5.
  - heal_pulse together with a hit at life=4 -> life=3 (heal dropped).
  - heal_pulse during INVULN at life=3 -> life=4.
- Fall: chara_y=480 during INVULN at life=4 -> life=0 immediately, DYING, no hit_pulse. chara_y=479 -> no effect.
- Restart paths:
  - In OVER, change stage 2->3 -> next cycle life=5, ALIVE, gameover=0.
  - restart_sw held high -> only one restart.
  - reset_n low mid-DYING -> full reset values.
